int_seq: RTL and testbench
==========================

// Module: int_seq
// PURPOSE
//  Interrupt/reset front end for the 65C02 core; sits directly upstream of the microcode controller.
//  - Synchronises the raw IRQ/NMI pins and edge-detects NMI.
//  - Stretches and synchronises reset into the active-high core reset.
//  - Presents the interrupt request and effective I mask that the controller samples at sync.
//  - Holds a stable vector select until the microcode vector fetch acknowledges it.
// PARAMETERS
//  RESET_CYCLES  4  cycles core_reset stays high after synchronised release of reset_n (>=1)
//  SYNC_STAGES   2  flop stages on irq_n, nmi_n and reset release (>=2)
// PORTS
//  clk         in   1  core clock
//  reset_n     in   1  asynchronous, active-low reset
//  irq_n       in   1  raw IRQ pin, level, async
//  nmi_n       in   1  raw NMI pin, falling-edge, async
//  sync        in   1  controller sync (instruction decode cycle)
//  I           in   1  processor I flag
//  vec_ack     in   1  microcode vector low-byte read; ends service
//  core_reset  out  1  active-high reset to controller
//  int_req     out  1  to controller irq input
//  int_mask    out  1  to controller I input; I & ~nmi_pending
//  vec         out  2  VEC_NMI=01 (FFFA), VEC_RES=10 (FFFC), VEC_IRQ=11 (FFFE)
//  in_service  out  1  high from accept to vec_ack
// BEHAVIOUR
//  - One clock, clk. reset_n asserts asynchronously and clears every flop.
//  - Reset values: core_reset=1, int_req=0, int_mask=1, vec=VEC_RES, in_service=0,
//    nmi_pending=0, state=HOLD.
//  - Reset release: reset_n deassertion passes SYNC_STAGES flops, then a counter loads RESET_CYCLES.
//    core_reset falls on the edge the counter reaches 0; state goes to RUN.
//    Total release latency is SYNC_STAGES+RESET_CYCLES cycles.
//  - irq_s/nmi_s: SYNC_STAGES-flop synchronised pins, reset value 1.
//  - NMI detect: an nmi_s 1->0 sets nmi_pending. A held-low nmi_n gives exactly one pending.
//    Set wins over a same-cycle clear.
//  - int_req = state==RUN & (~irq_s | nmi_pending). Combinational from registers; zero latency.
//  - FSM HOLD -> RUN -> SVC:
//    - HOLD: core_reset=1; exits per reset release above.
//    - RUN -> SVC on clk edge where sync & int_req & ~int_mask.
//      Latch vec=VEC_NMI if nmi_pending (clear it), else VEC_IRQ. NMI has priority over IRQ.
//    - SVC: in_service=1; int_req=0; vec frozen.
//      New NMI edges still set nmi_pending. IRQ level is not latched.
//    - SVC -> RUN on vec_ack. A pending NMI is then requested at the next sync.
//    - vec_ack outside SVC is ignored.
//  - int_mask = I & ~nmi_pending in all states. NMI is never masked by I.
//  - Simultaneous IRQ+NMI: NMI taken first; IRQ (still low) is taken at a later sync if I=0.
//  - Reset mid-operation: reset_n low in any state -> HOLD immediately.
//    nmi_pending cleared; vec=VEC_RES.
//  - IRQ deasserted before sync: no service, no latching (level semantics).
// CONFIGURATION
//  - INT_SEQ_NMI_EN defined: NMI path as above.
//  - Not defined: nmi_n port kept but ignored; nmi_pending tied 0.
//    int_mask = I; VEC_NMI never produced.
// STRUCTURE
//  - Shared package/include cpu_pkg: VEC_NMI/VEC_RES/VEC_IRQ codes and FSM state encodings
//    ST_HOLD/ST_RUN/ST_SVC (2-bit), shared with the microcode vector-fetch logic.
//  - One sub-module: sync_ff #(SYNC_STAGES, RESET_VAL). Multi-stage synchroniser with async clear.
//    Instantiated for irq_n, nmi_n and reset release.
//  - Everything else is flat in int_seq.
// TESTING
//  1. reset_n low 3 cycles, release -> core_reset high exactly 2+4=6 cycles after release edge;
//     vec=10 throughout; int_req=0.
//  2. irq_n=0, I=1, sync pulses -> no SVC, int_req=1, in_service stays 0.
//     Then I=0 -> SVC at next sync, vec=11; vec_ack -> in_service=0.
//  3. Single nmi_n falling edge held low 50 cycles, I=1 -> int_mask=0 after 2+1 cycles.
//     One SVC, vec=01; no second service after vec_ack.
//  4. irq_n and nmi_n fall same cycle, I=0 -> first service vec=01.
//     After vec_ack, next sync -> service vec=11.
//  5. reset_n pulsed low while in SVC -> core_reset=1, in_service=0, vec=10 asynchronously;
//     pending NMI discarded.
//  6. Build without INT_SEQ_NMI_EN, toggle nmi_n with I=0, irq_n=1 -> int_req stays 0, vec never 01.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: vector select codes and sequencer state encodings shared with the microcode vector fetch
package cpu_pkg;
  localparam logic [1:0] VEC_NMI = 2'b01;
  localparam logic [1:0] VEC_RES = 2'b10;
  localparam logic [1:0] VEC_IRQ = 2'b11;
  localparam logic [1:0] ST_HOLD = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_SVC  = 2'b10;
endpackage

// File: rtl/int_seq_if.sv
// int_seq_if: pins, controller handshake and sequencer outputs; master drives inputs, slave is int_seq
interface int_seq_if;
  logic       irq_n;
  logic       nmi_n;
  logic       sync;
  logic       I;
  logic       vec_ack;
  logic       core_reset;
  logic       int_req;
  logic       int_mask;
  logic [1:0] vec;
  logic       in_service;
  modport master (output irq_n, nmi_n, sync, I, vec_ack,
                  input  core_reset, int_req, int_mask, vec, in_service);
  modport slave  (input  irq_n, nmi_n, sync, I, vec_ack,
                  output core_reset, int_req, int_mask, vec, in_service);
endinterface

// File: rtl/sync_ff.sv
// sync_ff: multi-stage synchroniser with asynchronous clear to RESET_VAL
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] s;
  // shift the async input through STAGES flops
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) s <= {STAGES{RESET_VAL}};
    else s <= {s[STAGES-2:0], d};
  assign q = s[STAGES-1];
endmodule

// File: rtl/int_seq.sv
// int_seq: 65C02 interrupt/reset front end; NMI path built only when INT_SEQ_NMI_EN is defined
module int_seq import cpu_pkg::*; #(
  parameter int RESET_CYCLES = 4,
  parameter int SYNC_STAGES  = 2
) (
  input logic       clk,
  input logic       reset_n,
  int_seq_if.slave  bus
);
  localparam int CW = $clog2(RESET_CYCLES + 1);
  logic          rel;
  logic          irq_s;
  logic          nmi_pending;
  logic          take;
  logic [1:0]    state;
  logic [1:0]    vec;
  logic [CW-1:0] cnt;
  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_rel (.clk(clk), .reset_n(reset_n), .d(1'b1), .q(rel));
  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_irq (.clk(clk), .reset_n(reset_n), .d(bus.irq_n), .q(irq_s));
`ifdef INT_SEQ_NMI_EN
  logic nmi_s;
  logic nmi_d;
  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_nmi (.clk(clk), .reset_n(reset_n), .d(bus.nmi_n), .q(nmi_s));
  // latch one pending NMI per synchronised falling edge; a new edge beats a same-cycle accept
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      nmi_d       <= 1'b1;
      nmi_pending <= 1'b0;
    end else begin
      nmi_d       <= nmi_s;
      nmi_pending <= (nmi_d & ~nmi_s) | (nmi_pending & ~take);
    end
`else
  assign nmi_pending = 1'b0;
`endif
  assign bus.int_mask   = bus.I & ~nmi_pending;
  assign bus.int_req    = (state == ST_RUN) & (~irq_s | nmi_pending);
  assign bus.core_reset = state == ST_HOLD;
  assign bus.in_service = state == ST_SVC;
  assign bus.vec        = vec;
  assign take           = bus.sync & bus.int_req & ~bus.int_mask;
  // HOLD stretches reset, RUN accepts at sync, SVC freezes vec until the vector fetch acks
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= ST_HOLD;
      cnt   <= CW'(RESET_CYCLES);
      vec   <= VEC_RES;
    end else begin
      if (state == ST_HOLD && rel) begin
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) state <= ST_RUN;
      end
      if (take) begin
        state <= ST_SVC;
        vec   <= nmi_pending ? VEC_NMI : VEC_IRQ;
      end
      if (state == ST_SVC && bus.vec_ack) state <= ST_RUN;
    end
endmodule

// File: tb/tb_int_seq.sv
// tb_int_seq: directed checks of reset stretch, IRQ masking, NMI edge/priority and mid-service reset
module tb_int_seq;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   passed = 0;
  int   n;
  int_seq_if bus();
  int_seq #(.RESET_CYCLES(4), .SYNC_STAGES(2)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask
  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic pulse_sync();
    bus.sync = 1'b1;
    cyc(1);
    bus.sync = 1'b0;
  endtask
  task automatic pulse_ack();
    bus.vec_ack = 1'b1;
    cyc(1);
    bus.vec_ack = 1'b0;
  endtask
  task automatic release_rst(output int edges, output int vec_bad);
    edges = 0;
    vec_bad = 0;
    reset_n = 1'b1;
    while (bus.core_reset === 1'b1 && edges < 20) begin
      cyc(1);
      edges++;
      if (bus.vec !== 2'b10) vec_bad++;
    end
  endtask
  initial begin
    int vb;
    bus.irq_n = 1'b1;
    bus.nmi_n = 1'b1;
    bus.sync = 1'b0;
    bus.I = 1'b1;
    bus.vec_ack = 1'b0;
    cyc(3);
    chk("rst_core", bus.core_reset, 1);
    chk("rst_req", bus.int_req, 0);
    chk("rst_mask", bus.int_mask, 1);
    chk("rst_vec", bus.vec, 2'b10);
    chk("rst_svc", bus.in_service, 0);
    release_rst(n, vb);
    chk("rel_latency", n, 6);
    chk("rel_vec_hold", vb, 0);
    chk("rel_req", bus.int_req, 0);
    bus.irq_n = 1'b0;
    cyc(3);
    chk("irq_req", bus.int_req, 1);
    repeat (3) pulse_sync();
    chk("irq_masked", bus.in_service, 0);
    bus.I = 1'b0;
    pulse_sync();
    chk("irq_svc", bus.in_service, 1);
    chk("irq_vec", bus.vec, 2'b11);
    chk("svc_req", bus.int_req, 0);
    pulse_ack();
    chk("irq_ack", bus.in_service, 0);
    bus.irq_n = 1'b1;
    cyc(3);
    chk("irq_off", bus.int_req, 0);
    bus.I = 1'b1;
`ifdef INT_SEQ_NMI_EN
    bus.nmi_n = 1'b0;
    cyc(2);
    chk("nmi_mask2", bus.int_mask, 1);
    cyc(1);
    chk("nmi_mask3", bus.int_mask, 0);
    chk("nmi_req", bus.int_req, 1);
    pulse_sync();
    chk("nmi_svc", bus.in_service, 1);
    chk("nmi_vec", bus.vec, 2'b01);
    chk("nmi_clr", bus.int_mask, 1);
    pulse_ack();
    cyc(30);
    pulse_sync();
    chk("nmi_once", bus.in_service, 0);
    chk("nmi_once_req", bus.int_req, 0);
    bus.nmi_n = 1'b1;
    cyc(4);
    bus.I = 1'b0;
    bus.irq_n = 1'b0;
    bus.nmi_n = 1'b0;
    cyc(4);
    pulse_sync();
    chk("both_first", bus.vec, 2'b01);
    pulse_ack();
    pulse_sync();
    chk("both_second", bus.vec, 2'b11);
    chk("both_svc", bus.in_service, 1);
    pulse_ack();
    bus.irq_n = 1'b1;
    bus.nmi_n = 1'b1;
    cyc(4);
    bus.irq_n = 1'b0;
    cyc(3);
    pulse_sync();
    chk("mid_svc", bus.in_service, 1);
    bus.nmi_n = 1'b0;
    bus.I = 1'b1;
    cyc(4);
    chk("mid_pending", bus.int_mask, 0);
    chk("mid_frozen", bus.vec, 2'b11);
`else
    pulse_sync();
    bus.I = 1'b0;
    bus.irq_n = 1'b0;
    cyc(3);
    pulse_sync();
    chk("mid_svc", bus.in_service, 1);
    bus.I = 1'b1;
`endif
    #2 reset_n = 1'b0;
    #1;
    chk("async_core", bus.core_reset, 1);
    chk("async_svc", bus.in_service, 0);
    chk("async_vec", bus.vec, 2'b10);
    chk("async_mask", bus.int_mask, 1);
    bus.irq_n = 1'b1;
    bus.nmi_n = 1'b1;
    cyc(2);
    release_rst(n, vb);
    chk("rel2_latency", n, 6);
    cyc(3);
    chk("rel2_mask", bus.int_mask, 1);
    chk("rel2_req", bus.int_req, 0);
`ifndef INT_SEQ_NMI_EN
    bus.I = 1'b0;
    vb = 0;
    repeat (4) begin
      bus.nmi_n = ~bus.nmi_n;
      cyc(3);
      if (bus.int_req !== 1'b0) vb++;
      pulse_sync();
      if (bus.vec === 2'b01 || bus.in_service !== 1'b0) vb++;
    end
    chk("nonmi_quiet", vb, 0);
    chk("nonmi_mask", bus.int_mask, 0);
    chk("nonmi_vec", bus.vec, 2'b10);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
